// File: rtl/flappy_button_conditioner.sv
// Debounces one raw pushbutton into a synchronous active-high level, with
// press/release strobes and a wrapping press counter.
//
// state        | meaning
// RELEASED     | accepted level is released, waiting for a pressed sample
// WAIT_PRESS   | qualifying a press, cnt = consecutive pressed samples seen
// PRESSED      | accepted level is pressed, waiting for a released sample
// WAIT_RELEASE | qualifying a release, cnt = consecutive released samples seen
module flappy_button_conditioner #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 19,
  parameter bit ACTIVE_LOW      = 1'b1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       key_raw,
  output logic       level_out,
  output logic       press_pulse,
  output logic       release_pulse,
  output logic [7:0] press_count
);

  localparam logic IDLE_LVL = ACTIVE_LOW ? 1'b1 : 1'b0;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    RELEASED     = 2'd0,
    WAIT_PRESS   = 2'd1,
    PRESSED      = 2'd2,
    WAIT_RELEASE = 2'd3
  } state_t;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   press_evt;
  logic                   release_evt;
  logic                   level_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= {SYNC_STAGES{IDLE_LVL}};
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], key_raw};
    end
  end

  assign s = sync_q[SYNC_STAGES-1] ^ IDLE_LVL;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= RELEASED;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      RELEASED: begin
        if (s) begin
          state_d = WAIT_PRESS;
          cnt_d   = CNT_ONE;
        end
      end
      WAIT_PRESS: begin
        if (!s) begin
          state_d = RELEASED;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = PRESSED;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      PRESSED: begin
        if (!s) begin
          state_d = WAIT_RELEASE;
          cnt_d   = CNT_ONE;
        end
      end
      WAIT_RELEASE: begin
        if (s) begin
          state_d = PRESSED;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = RELEASED;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = RELEASED;
        cnt_d   = '0;
      end
    endcase
  end

  // The registered level still shows the old value on the first cycle of a
  // newly accepted state, which is exactly when each strobe must fire.
  assign level_d     = (state_q == PRESSED) || (state_q == WAIT_RELEASE);
  assign press_evt   = (state_q == PRESSED) && !level_out;
  assign release_evt = (state_q == RELEASED) && level_out;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      level_out     <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      press_count   <= 8'd0;
    end else begin
      level_out     <= level_d;
      press_pulse   <= press_evt;
      release_pulse <= release_evt;
      if (press_evt) begin
        press_count <= press_count + 8'd1;
      end
    end
  end

endmodule
